// File: rtl/noc_msg_serializer.sv
// Serializes one wide NoC message (header flit 0 plus payload) into a
// flit-by-flit valid/ready stream, clamping oversize length fields.
module noc_msg_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_FLITS  = 9,
  parameter int LEN_LO     = 22,
  parameter int LEN_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MAX_FLITS*DATA_WIDTH-1:0] msg_in,
  input  logic                            msg_valid,
  output logic                            msg_ready,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  input  logic                            ready_out,
  output logic                            busy,
  output logic                            err_oversize
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid, once raised, holds with stable data until accepted.

  localparam int IDX_W = $clog2(MAX_FLITS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FLITS - 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_FLITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] flit_q  [MAX_FLITS];
  logic [DATA_WIDTH-1:0] flit_in [MAX_FLITS];
  logic [IDX_W-1:0]      idx_q, last_q, idx_nxt, last_in;
  logic [LEN_W-1:0]      len_in;
  logic [DATA_WIDTH-1:0] hdr_fixed;
  logic                  oversize, in_fire, out_fire, at_last;

  // Unpack the message and clamp the header length to what the buffer holds.
  always_comb begin
    for (int i = 0; i < MAX_FLITS; i++) begin
      flit_in[i] = msg_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    len_in    = msg_in[LEN_LO +: LEN_W];
    oversize  = (len_in > MAX_LEN);
    hdr_fixed = flit_in[0];
    if (oversize) begin
      hdr_fixed[LEN_LO +: LEN_W] = MAX_LEN;
    end
    last_in = oversize ? MAX_IDX : IDX_W'(len_in);
  end

  assign msg_ready = (state_q == IDLE);
  assign valid_out = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign in_fire   = msg_valid && msg_ready;
  assign out_fire  = valid_out && ready_out;
  assign at_last   = (idx_q == last_q);
  assign idx_nxt   = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_fire) state_d = SEND;
      SEND: if (out_fire && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: the next flit is staged on the same edge that accepts the
  // current one, giving one flit per cycle under continuous ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      last_q       <= '0;
      data_out     <= '0;
      err_oversize <= 1'b0;
      for (int i = 0; i < MAX_FLITS; i++) begin
        flit_q[i] <= '0;
      end
    end else begin
      err_oversize <= in_fire && oversize;
      if (in_fire) begin
        for (int i = 1; i < MAX_FLITS; i++) begin
          flit_q[i] <= flit_in[i];
        end
        flit_q[0] <= hdr_fixed;
        data_out  <= hdr_fixed;
        idx_q     <= '0;
        last_q    <= last_in;
      end else if (out_fire) begin
        if (!at_last) begin
          idx_q    <= idx_nxt;
          data_out <= flit_q[idx_nxt];
        end else begin
          idx_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_msg_serializer.sv
// Randomized scoreboard bench for noc_msg_serializer: a driver pushes the
// expected flit sequence per message, a negedge monitor pops and compares.
module tb_noc_msg_serializer;

  localparam int DW = 64;
  localparam int MF = 9;
  localparam int LL = 22;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [MF*DW-1:0] msg_in;
  logic            msg_valid;
  logic            msg_ready;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic            ready_out;
  logic            busy;
  logic            err_oversize;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int  rdy_mode = 0;
  int  tog_i = 0;
  bit  keep_valid = 0;

  noc_msg_serializer #(
    .DATA_WIDTH(DW), .MAX_FLITS(MF), .LEN_LO(LL), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .msg_in(msg_in), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .busy(busy), .err_oversize(err_oversize)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_out = 1'b1;
        1:       ready_out = 1'($urandom_range(0, 1));
        default: begin
          ready_out = (tog_i % 3 == 0);
          tog_i++;
        end
      endcase
    end
  end

  // ---------------- message driver ----------------
  task automatic send(input int len, input bit seq_payload);
    logic [DW-1:0] fl [MF];
    logic [DW-1:0] ehdr;
    logic [MF*DW-1:0] m;
    int n_out;
    int n;
    bit ovs;
    fl[0] = {$urandom, $urandom};
    fl[0][LL +: LW] = LW'(len);
    for (int i = 1; i < MF; i++) fl[i] = seq_payload ? DW'(i) : {$urandom, $urandom};
    for (int i = 0; i < MF; i++) m[i*DW +: DW] = fl[i];
    ovs   = (len > MF - 1);
    n_out = ovs ? MF - 1 : len;
    ehdr  = fl[0];
    ehdr[LL +: LW] = LW'(n_out);

    @(negedge clk);
    msg_in    = m;
    msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!msg_ready) begin
      checks++;
      errors++;
      $display("FAIL msg_ready_timeout: got 0 expected 1 at %0t", $time);
      msg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(ehdr);
    for (int i = 1; i <= n_out; i++) exp_q.push_back(fl[i]);
    // Header must be presented exactly one cycle after acceptance.
    @(negedge clk);
    if (!keep_valid) msg_valid = 1'b0;
    msg_in = {MF{DW'(64'hdead_beef_0bad_f00d)}};
    chk("first_flit_valid", valid_out, 1'b1);
    chk("first_flit_hdr", data_out, ehdr);
    chk("err_pulse", err_oversize, ovs);
    @(negedge clk);
    chk("err_clear", err_oversize, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    bit pend;
    logic [DW-1:0] pend_data;
    pend = 0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
      end else begin
        chk("valid_out", valid_out, exp_q.size() != 0);
        chk("busy", busy, exp_q.size() != 0);
        chk("msg_ready", msg_ready, exp_q.size() == 0);
        if (pend) chk("hold_data", data_out, pend_data);
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_flit: got %0h expected none", data_out);
          end else begin
            chk("flit", data_out, exp_q.pop_front());
          end
          pend = 0;
        end else begin
          pend = valid_out;
          pend_data = data_out;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg_in    = '0;
    #1;
    chk("rst_msg_ready", msg_ready, 1'b1);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_err", err_oversize, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 0;
    send(0, 1'b0);
    drain();
    send(8, 1'b1);
    drain();
    rdy_mode = 2;
    tog_i = 0;
    send(3, 1'b0);
    drain();
    rdy_mode = 0;
    send(12, 1'b0);
    drain();

    keep_valid = 1;
    send(4, 1'b0);
    keep_valid = 0;
    send(6, 1'b0);
    drain();

    // Abort a len=5 message while flit 2 is on the output.
    send(5, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid_out", valid_out, 1'b0);
    chk("abort_msg_ready", msg_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(1, 1'b0);
    drain();

    rdy_mode = 1;
    repeat (30) begin
      send($urandom_range(0, 15), 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/noc_msg_serializer.md
Name: noc_msg_serializer

Overview:
Transmit-side counterpart of the chipset store-and-forward message buffer. It accepts one complete NoC message, header plus payload, as a single wide parallel word in one valid/ready handshake. It then emits the message flit by flit on a standard NoC valid/ready output. It sits between chipset-side request generators and the NoC output port, so that producers never deal with per-flit sequencing.

Parameters:
DATA_WIDTH, 64 (NOC_DATA_WIDTH), width of one flit.
MAX_FLITS, 9, buffer depth in flits (header flit 0 plus up to 8 payload flits).
LEN_LO, 22, LSB of the MSG_LENGTH field in header flit 0.
LEN_W, 8, width of the MSG_LENGTH field; it counts the flits following the header.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
msg_in  in  MAX_FLITS*DATA_WIDTH  full message; flit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; flit 0 is the header
msg_valid  in  1  msg_in holds a message
msg_ready  out  1  block can accept a message
data_out  out  DATA_WIDTH  current flit
valid_out  out  1  data_out is valid
ready_out  in  1  downstream accepts the flit
busy  out  1  a message is being sent
err_oversize  out  1  one-cycle pulse when an accepted header requests more than MAX_FLITS-1 payload flits

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All state is async-cleared.
- Reset values: msg_ready=1, data_out=0, valid_out=0, busy=0, err_oversize=0, state=IDLE, flit index=0.
- Handshakes: in_fire = msg_valid && msg_ready. out_fire = valid_out && ready_out.
- FSM, state IDLE:
  - msg_ready=1, valid_out=0.
  - On in_fire, capture all MAX_FLITS flits of msg_in into the internal buffer.
  - Compute last = min(len, MAX_FLITS-1), where len = msg_in[LEN_LO +: LEN_W].
  - Register data_out <= flit 0 and move to SEND.
  - valid_out=1 from the cycle after in_fire; acceptance-to-first-flit latency is 1 cycle.
- FSM, state SEND:
  - msg_ready=0, busy=1, valid_out=1.
  - On out_fire with idx < last: idx <= idx+1 and data_out <= buf[idx+1] in the same edge. The next flit appears the following cycle, so the output sustains 1 flit per cycle with ready_out held high.
  - On out_fire with idx == last: go to IDLE, valid_out <= 0, idx <= 0. msg_ready returns to 1 the next cycle.
  - No same-cycle refill, so there is at least one idle cycle between messages.
- Backpressure: while valid_out && !ready_out, data_out and valid_out hold stable. valid_out never drops before the flit is accepted.
- msg_in is don't-care outside in_fire. Changing it mid-send has no effect on the message being sent.
- Oversize header (len > MAX_FLITS-1):
  - The message is truncated to MAX_FLITS flits.
  - The header flit as emitted has its length field rewritten to MAX_FLITS-1; all other header bits are unchanged.
  - err_oversize pulses high for exactly the cycle after in_fire.
  - A legal len passes through with the header unmodified and err_oversize=0.
- len=0: a single-flit message. The header is sent and the FSM returns to IDLE on that flit's out_fire.
- Unused buffer slots beyond last are never emitted.
- Reset mid-message: rst_n low aborts immediately. valid_out drops asynchronously, the partial message is discarded, and the FSM restarts in IDLE with msg_ready=1 after reset release.
- Outputs msg_ready, valid_out and busy are decoded from registered state only; there is no combinational path from inputs to outputs.
- Width rule: the idx register is clog2(MAX_FLITS) bits. The len comparison uses the full LEN_W bits, so there is no wrap-around.

Test Plan:
- Header len=0, ready_out=1 -> in_fire at T, then exactly 1 flit with data_out=header and valid_out high only at T+1; msg_ready=1 again at T+2.
- len=8, payload flits 0x1..0x8, ready_out=1 -> 9 consecutive flits, header then 0x1..0x8, on cycles T+1..T+9; busy high throughout; err_oversize=0.
- len=3, ready_out toggling 1,0,0,1,... -> 4 flits in order; data_out/valid_out stable during every ready_out=0 cycle; no flit duplicated or skipped.
- len=12 -> 9 flits emitted; emitted header length field=8; err_oversize=1 for exactly one cycle (T+1).
- Two messages offered back-to-back (msg_valid held high) -> second msg_ready asserts one cycle after the first message's last out_fire; the second message's flit 0 appears one cycle after its in_fire.
- Assert rst_n=0 during flit 2 of a len=5 message -> valid_out=0 and msg_ready=1 immediately; after release, a new len=1 message sends exactly 2 correct flits.
